// File: rtl/inv_mixcolumns_serial.sv
// Byte-serial AES InvMixColumns: LANES output bytes per cycle over 16/LANES cycles.
// Define MIXCOL_FWD_EN to add a fwd port that selects forward MixColumns per operation.
module inv_mixcolumns_serial #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
`ifdef MIXCOL_FWD_EN
  input  logic         fwd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_check
    $error("inv_mixcolumns_serial: LANES must be 1, 2 or 4");
  end

  localparam int         NCYC = 16 / ((LANES > 0) ? LANES : 1);
  localparam logic [3:0] LAST = 4'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state;
  logic [127:0] in_reg;
  logic [3:0]   cnt;
  logic         mode;
  logic [127:0] calc_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant coefficient c (<= 0x0f) times x, built from the x2/x4/x8 chain.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] s, input logic [3:0] k);
    return 8'(s >> {4'd15 - k, 3'b000});
  endfunction

  // Computes output byte k and returns it already placed in its 128-bit slot.
  function automatic logic [127:0] mix_lane(input logic [127:0] s, input logic [3:0] k,
                                            input logic f);
    logic [1:0] r;
    logic [7:0] a0, a1, a2, a3, b;
    r  = k[1:0];
    a0 = byte_of(s, {k[3:2], r});
    a1 = byte_of(s, {k[3:2], r + 2'd1});
    a2 = byte_of(s, {k[3:2], r + 2'd2});
    a3 = byte_of(s, {k[3:2], r + 2'd3});
    if (f)
      b = gmul(a0, 4'h2) ^ gmul(a1, 4'h3) ^ a2 ^ a3;
    else
      b = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
    return 128'(b) << {4'd15 - k, 3'b000};
  endfunction

`ifdef MIXCOL_FWD_EN
  logic fwd_q;
  assign mode = fwd_q;
`else
  assign mode = 1'b0;
`endif

  // Bytes not yet written are still zero, so new lanes can simply be OR-ed in.
  always_comb begin
    calc_out = state_out;
    for (int unsigned l = 0; l < LANES; l++) begin
      calc_out = calc_out | mix_lane(in_reg, 4'(int'(cnt) * LANES + int'(l)), mode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      state_out <= '0;
      in_reg    <= '0;
      cnt       <= '0;
`ifdef MIXCOL_FWD_EN
      fwd_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg    <= state_in;
            state_out <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= CALC;
`ifdef MIXCOL_FWD_EN
            fwd_q     <= fwd;
`endif
          end
        end
        CALC: begin
          state_out <= calc_out;
          cnt       <= cnt + 4'd1;
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mixcolumns_serial.sv
// Randomized bench for inv_mixcolumns_serial at LANES=1,2,4 against a GF(2^8) matrix model.
module tb_inv_mixcolumns_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   in_valid_v, in_ready_v, out_valid_v, out_ready_v, busy_v;
  logic [127:0] state_in_v  [3];
  logic [127:0] state_out_v [3];
`ifdef MIXCOL_FWD_EN
  logic [2:0]   fwd_v;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KNOWN_IN  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] KNOWN_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mixcolumns_serial #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .state_in  (state_in_v[g]),
`ifdef MIXCOL_FWD_EN
      .fwd       (fwd_v[g]),
`endif
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .state_out (state_out_v[g]),
      .busy      (busy_v[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Generic shift-and-add multiplication in GF(2^8) mod 0x11b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input bit f);
    logic [7:0]   b [16];
    logic [7:0]   co [4];
    logic [7:0]   y;
    logic [127:0] o = '0;
    if (f) co = '{8'h02, 8'h03, 8'h01, 8'h01};
    else   co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int k = 0; k < 16; k++) b[k] = s[127 - 8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        y = 8'h00;
        for (int j = 0; j < 4; j++) y = y ^ gf_mul(co[j], b[4*c + (r + j) % 4]);
        o[127 - 8*(4*c + r) -: 8] = y;
      end
    return o;
  endfunction

  task automatic run_op(input int idx, input logic [127:0] data, input bit fwdm, input int hold);
    int           ncyc = 16 >> idx;
    int           cyc  = 0;
    bit           bad  = 1'b0;
    logic [127:0] exp  = model(data, fwdm);
    logic [127:0] snap;
    out_ready_v[idx] = (hold == 0);
    while (!in_ready_v[idx] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("idle_ready_l%0d", idx), in_ready_v[idx], 1'b1);
    state_in_v[idx] = data;
    in_valid_v[idx] = 1'b1;
`ifdef MIXCOL_FWD_EN
    fwd_v[idx] = fwdm;
`endif
    @(negedge clk);
    in_valid_v[idx] = 1'b0;
    state_in_v[idx] = rand128();
`ifdef MIXCOL_FWD_EN
    fwd_v[idx] = ~fwdm;
`endif
    cyc = 0;
    while (!out_valid_v[idx] && cyc < 100) begin
      if (in_ready_v[idx] || !busy_v[idx]) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check($sformatf("latency_l%0d", idx), cyc, ncyc);
    check($sformatf("calc_ctrl_l%0d", idx), bad, 1'b0);
    check($sformatf("result_l%0d", idx), state_out_v[idx], exp);
    check($sformatf("done_ctrl_l%0d", idx), {in_ready_v[idx], busy_v[idx]}, 2'b01);
    if (hold > 0) begin
      bad  = 1'b0;
      snap = state_out_v[idx];
      repeat (hold) begin
        in_valid_v[idx] = 1'($urandom_range(0, 1));
        state_in_v[idx] = rand128();
        @(negedge clk);
        if (!out_valid_v[idx] || in_ready_v[idx] || state_out_v[idx] !== snap) bad = 1'b1;
      end
      in_valid_v[idx] = 1'b0;
      check($sformatf("hold_stable_l%0d", idx), bad, 1'b0);
      out_ready_v[idx] = 1'b1;
    end
    @(negedge clk);
    check($sformatf("back_idle_l%0d", idx),
          {out_valid_v[idx], in_ready_v[idx], busy_v[idx]}, 3'b010);
    check($sformatf("retain_l%0d", idx), state_out_v[idx], exp);
  endtask

  task automatic b2b(input int idx);
    int           ncyc   = 16 >> idx;
    int           t      = 0;
    int           first  = -1;
    int           second = -1;
    int           cyc    = 0;
    bit           bad    = 1'b0;
    logic [127:0] d2     = '0;
    out_ready_v[idx] = 1'b1;
    in_valid_v[idx]  = 1'b1;
    state_in_v[idx]  = rand128();
    while (second < 0 && t < 200) begin
      if (in_ready_v[idx] && out_valid_v[idx]) bad = 1'b1;
      if (in_ready_v[idx]) begin
        if (first < 0) first = t;
        else begin
          second = t;
          d2 = state_in_v[idx];
        end
      end
      @(negedge clk);
      t++;
      state_in_v[idx] = rand128();
    end
    in_valid_v[idx] = 1'b0;
    check($sformatf("b2b_spacing_l%0d", idx), second - first, ncyc + 2);
    check($sformatf("b2b_ready_vs_valid_l%0d", idx), bad, 1'b0);
    while (!out_valid_v[idx] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("b2b_result_l%0d", idx), state_out_v[idx], model(d2, 1'b0));
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '0;
    for (int i = 0; i < 3; i++) state_in_v[i] = '0;
`ifdef MIXCOL_FWD_EN
    fwd_v = '0;
`endif
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ctrl_l%0d", i), {in_ready_v[i], out_valid_v[i], busy_v[i]}, 3'b100);
      check($sformatf("rst_data_l%0d", i), state_out_v[i], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, KNOWN_IN, 1'b0, 0);
    check("known_vector", state_out_v[0], KNOWN_OUT);
    run_op(0, {16{8'h01}}, 1'b0, 0);
    check("ones_identity", state_out_v[0], {16{8'h01}});
    run_op(0, '0, 1'b0, 0);
    check("zero_identity", state_out_v[0], '0);
    run_op(0, rand128(), 1'b0, 10);

    // Abort mid-computation, then confirm a fresh operation is clean.
    state_in_v[0]  = rand128();
    out_ready_v[0] = 1'b1;
    in_valid_v[0]  = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", {in_ready_v[0], out_valid_v[0], busy_v[0]}, 3'b100);
    check("abort_data", state_out_v[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, rand128(), 1'b0, 0);

    for (int idx = 0; idx < 3; idx++)
      repeat (3) run_op(idx, rand128(), 1'b0, int'($urandom_range(0, 3)));
    for (int idx = 0; idx < 3; idx++) b2b(idx);

`ifdef MIXCOL_FWD_EN
    run_op(0, KNOWN_OUT, 1'b1, 0);
    check("fwd_known", state_out_v[0], KNOWN_IN);
    run_op(0, KNOWN_IN, 1'b0, 0);
    check("inv_known_again", state_out_v[0], KNOWN_OUT);
    for (int idx = 0; idx < 3; idx++)
      repeat (2) run_op(idx, rand128(), 1'($urandom_range(0, 1)), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
